sprite_motion_ctrl: RTL and testbench

- Parametrised successor to the single-sprite Pac-Man movement block.
- Per-frame direction control with:
  - a buffered (queued) turn that expires after a set number of frames,
  - a speed divider for per-sprite speed,
  - a parametrised horizontal tunnel wrap,
  - an explicit Kill-freeze / Respawn state machine.
- Wall detection stays external. The four wall-probe results are fed back on Blocked, evaluated at the current position.
- One instance per sprite: Pac-Man driven by keycode, ghosts driven by AI through the same keycode encoding.

---
 rtl/sprite_motion_ctrl_if.sv | 26 ++
 rtl/sprite_motion_ctrl.sv | 170 +++++++++++++++++
 tb/tb_sprite_motion_ctrl.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_motion_ctrl_if.sv
// rtl/sprite_motion_ctrl_if.sv - control/status bundle between a sprite driver and sprite_motion_ctrl
interface sprite_motion_ctrl_if #(
  parameter int W = 10
);
  logic [7:0]   keycode;
  logic [3:0]   Blocked;
  logic         Kill;
  logic         Respawn;
  logic [W-1:0] PosX;
  logic [W-1:0] PosY;
  logic [1:0]   Dir;
  logic         Moving;
  logic         Frozen;
  logic         Step_Pulse;
  logic         Queued_Valid;

  modport master (
    output keycode, Blocked, Kill, Respawn,
    input  PosX, PosY, Dir, Moving, Frozen, Step_Pulse, Queued_Valid
  );

  modport slave (
    input  keycode, Blocked, Kill, Respawn,
    output PosX, PosY, Dir, Moving, Frozen, Step_Pulse, Queued_Valid
  );
endinterface

// File: rtl/sprite_motion_ctrl.sv
// rtl/sprite_motion_ctrl.sv - per-frame sprite movement: turn queue, speed divider, tunnel wrap, freeze/respawn
module sprite_motion_ctrl #(
  parameter int W               = 10,
  parameter int X_CENTER        = 320,
  parameter int Y_CENTER        = 274,
  parameter int STEP            = 1,
  parameter int SPEED_DIV       = 1,
  parameter int TURN_BUF_FRAMES = 8,
  parameter int TUNNEL_MIN      = 120,
  parameter int TUNNEL_MAX      = 520
) (
  input  logic                 frame_clk,
  input  logic                 Reset_n,
  sprite_motion_ctrl_if.slave  io_sprite
);

  localparam int DIV_W = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;
  localparam int QW    = $clog2(TURN_BUF_FRAMES + 1);

  typedef enum logic [1:0] {ST_STOPPED, ST_MOVING, ST_FROZEN} state_t;

  state_t           r_state,   w_state_nxt;
  logic             r_resume,  w_resume_nxt;
  logic [W-1:0]     r_pos_x,   w_pos_x_nxt;
  logic [W-1:0]     r_pos_y,   w_pos_y_nxt;
  logic [1:0]       r_dir,     w_dir_nxt;
  logic             r_q_valid, w_q_valid_nxt;
  logic [1:0]       r_q_dir,   w_q_dir_nxt;
  logic [QW-1:0]    r_q_cnt,   w_q_cnt_nxt;
  logic [DIV_W-1:0] r_div,     w_div_nxt;
  logic             r_step,    w_step_nxt;

  logic             w_key_valid;
  logic [1:0]       w_key_dir;
  logic             w_tick;
  logic [W:0]       w_x_ext;
  logic [W-1:0]     w_x_left;
  logic [W-1:0]     w_x_right;

  // Blocked is packed {up, down, left, right} while Dir counts up from 0 = up.
  function automatic logic f_blocked(input logic [3:0] b, input logic [1:0] d);
    return b[2'd3 - d];
  endfunction

  always_comb begin
    w_key_valid = 1'b1;
    w_key_dir   = 2'd0;
    case (io_sprite.keycode)
      8'h04:   w_key_dir = 2'd2;
      8'h07:   w_key_dir = 2'd3;
      8'h16:   w_key_dir = 2'd1;
      8'h1A:   w_key_dir = 2'd0;
      default: w_key_valid = 1'b0;
    endcase
  end

  assign w_tick    = (r_div == DIV_W'(SPEED_DIV - 1));
  assign w_x_ext   = {1'b0, r_pos_x};
  assign w_x_left  = (w_x_ext < (W+1)'(TUNNEL_MIN + STEP)) ? W'(TUNNEL_MAX) : r_pos_x - W'(STEP);
  assign w_x_right = ((w_x_ext + (W+1)'(STEP)) > (W+1)'(TUNNEL_MAX)) ? W'(TUNNEL_MIN)
                                                                     : r_pos_x + W'(STEP);

  always_comb begin
    w_state_nxt   = r_state;
    w_resume_nxt  = r_resume;
    w_pos_x_nxt   = r_pos_x;
    w_pos_y_nxt   = r_pos_y;
    w_dir_nxt     = r_dir;
    w_q_valid_nxt = r_q_valid;
    w_q_dir_nxt   = r_q_dir;
    w_q_cnt_nxt   = r_q_cnt;
    w_div_nxt     = r_div;
    w_step_nxt    = 1'b0;

    if (io_sprite.Respawn) begin
      w_state_nxt   = ST_STOPPED;
      w_resume_nxt  = 1'b0;
      w_pos_x_nxt   = W'(X_CENTER);
      w_pos_y_nxt   = W'(Y_CENTER);
      w_dir_nxt     = 2'd2;
      w_q_valid_nxt = 1'b0;
      w_q_cnt_nxt   = '0;
      w_div_nxt     = '0;
    end else if (io_sprite.Kill) begin
      if (r_state != ST_FROZEN) begin
        w_resume_nxt = (r_state == ST_MOVING);
        w_state_nxt  = ST_FROZEN;
      end
    end else if (r_state == ST_FROZEN) begin
      // Thaw edge: state change only, divider and position untouched.
      w_state_nxt = r_resume ? ST_MOVING : ST_STOPPED;
    end else begin
      if (w_key_valid) begin
        if (!f_blocked(io_sprite.Blocked, w_key_dir)) begin
          w_dir_nxt     = w_key_dir;
          w_q_valid_nxt = 1'b0;
          w_q_cnt_nxt   = '0;
          w_state_nxt   = ST_MOVING;
        end else begin
          w_q_valid_nxt = 1'b1;
          w_q_dir_nxt   = w_key_dir;
          w_q_cnt_nxt   = QW'(TURN_BUF_FRAMES);
        end
      end else if (r_q_valid) begin
        if (!f_blocked(io_sprite.Blocked, r_q_dir)) begin
          w_dir_nxt     = r_q_dir;
          w_q_valid_nxt = 1'b0;
          w_q_cnt_nxt   = '0;
          w_state_nxt   = ST_MOVING;
        end else begin
          w_q_cnt_nxt = r_q_cnt - QW'(1);
          if (r_q_cnt == QW'(1)) begin
            w_q_valid_nxt = 1'b0;
          end
        end
      end

      w_div_nxt = w_tick ? '0 : r_div + DIV_W'(1);

      if (w_tick && (w_state_nxt == ST_MOVING)) begin
        if (f_blocked(io_sprite.Blocked, w_dir_nxt)) begin
          w_state_nxt = ST_STOPPED;
        end else begin
          w_step_nxt = 1'b1;
          case (w_dir_nxt)
            2'd0:    w_pos_y_nxt = r_pos_y - W'(STEP);
            2'd1:    w_pos_y_nxt = r_pos_y + W'(STEP);
            2'd2:    w_pos_x_nxt = w_x_left;
            default: w_pos_x_nxt = w_x_right;
          endcase
        end
      end
    end
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= ST_STOPPED;
      r_resume  <= 1'b0;
      r_pos_x   <= W'(X_CENTER);
      r_pos_y   <= W'(Y_CENTER);
      r_dir     <= 2'd2;
      r_q_valid <= 1'b0;
      r_q_dir   <= 2'd0;
      r_q_cnt   <= '0;
      r_div     <= '0;
      r_step    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_resume  <= w_resume_nxt;
      r_pos_x   <= w_pos_x_nxt;
      r_pos_y   <= w_pos_y_nxt;
      r_dir     <= w_dir_nxt;
      r_q_valid <= w_q_valid_nxt;
      r_q_dir   <= w_q_dir_nxt;
      r_q_cnt   <= w_q_cnt_nxt;
      r_div     <= w_div_nxt;
      r_step    <= w_step_nxt;
    end
  end

  assign io_sprite.PosX         = r_pos_x;
  assign io_sprite.PosY         = r_pos_y;
  assign io_sprite.Dir          = r_dir;
  assign io_sprite.Moving       = (r_state == ST_MOVING);
  assign io_sprite.Frozen       = (r_state == ST_FROZEN);
  assign io_sprite.Step_Pulse   = r_step;
  assign io_sprite.Queued_Valid = r_q_valid;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb/tb_sprite_motion_ctrl.sv - bench for sprite_motion_ctrl: vector table, corner sequences, random vs. model
module tb_sprite_motion_ctrl;

  localparam int W     = 10;
  localparam int XC    = 320;
  localparam int YC    = 274;
  localparam int T_MIN = 120;
  localparam int T_MAX = 520;
  localparam int TBUF  = 8;
  localparam int MS_STOP = 0, MS_MOVE = 1, MS_FROZ = 2;

  logic       frame_clk = 1'b0;
  logic       Reset_n   = 1'b0;
  logic [7:0] t_key     = 8'h00;
  logic [3:0] t_blk     = 4'h0;
  logic       t_kill    = 1'b0;
  logic       t_resp    = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 frame_clk = ~frame_clk;

  sprite_motion_ctrl_if #(.W(W)) if_a ();
  sprite_motion_ctrl_if #(.W(W)) if_b ();

  assign if_a.keycode = t_key;
  assign if_a.Blocked = t_blk;
  assign if_a.Kill    = t_kill;
  assign if_a.Respawn = t_resp;
  assign if_b.keycode = t_key;
  assign if_b.Blocked = t_blk;
  assign if_b.Kill    = t_kill;
  assign if_b.Respawn = t_resp;

  sprite_motion_ctrl #(.W(W), .SPEED_DIV(1)) u_a (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .io_sprite (if_a)
  );

  sprite_motion_ctrl #(.W(W), .SPEED_DIV(3)) u_b (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .io_sprite (if_b)
  );

  typedef struct {
    logic [7:0] key;
    logic [3:0] blk;
    int x, y, d, mv, fz, st, qv;
  } vec_t;

  vec_t vecs[$];

  int m_x[2], m_y[2], m_dir[2], m_mode[2], m_resume[2];
  int m_qv[2], m_qdir[2], m_qleft[2], m_frames[2], m_step[2];

  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input int k, input string tag, input int x, input int y, input int d,
                           input int mv, input int fz, input int st, input int qv);
    int ax, ay, ad, amv, afz, ast, aqv;
    if (k == 0) begin
      ax = int'(if_a.PosX); ay = int'(if_a.PosY); ad = int'(if_a.Dir);
      amv = int'(if_a.Moving); afz = int'(if_a.Frozen);
      ast = int'(if_a.Step_Pulse); aqv = int'(if_a.Queued_Valid);
    end else begin
      ax = int'(if_b.PosX); ay = int'(if_b.PosY); ad = int'(if_b.Dir);
      amv = int'(if_b.Moving); afz = int'(if_b.Frozen);
      ast = int'(if_b.Step_Pulse); aqv = int'(if_b.Queued_Valid);
    end
    chk({tag, ".PosX"}, ax, x);
    chk({tag, ".PosY"}, ay, y);
    chk({tag, ".Dir"}, ad, d);
    chk({tag, ".Moving"}, amv, mv);
    chk({tag, ".Frozen"}, afz, fz);
    chk({tag, ".Step_Pulse"}, ast, st);
    chk({tag, ".Queued_Valid"}, aqv, qv);
  endtask

  task automatic add_vec(input logic [7:0] key, input logic [3:0] blk, input int x, input int y,
                         input int d, input int mv, input int fz, input int st, input int qv);
    vec_t v;
    v.key = key; v.blk = blk; v.x = x; v.y = y; v.d = d;
    v.mv = mv; v.fz = fz; v.st = st; v.qv = qv;
    vecs.push_back(v);
  endtask

  task automatic model_reset(input int k);
    m_x[k] = XC; m_y[k] = YC; m_dir[k] = 2; m_mode[k] = MS_STOP; m_resume[k] = 0;
    m_qv[k] = 0; m_qdir[k] = 0; m_qleft[k] = 0; m_frames[k] = 0; m_step[k] = 0;
  endtask

  // Reference behaviour: frames counts live (non-frozen) edges since spawn; every div-th is a move.
  task automatic model_edge(input int k, input logic [7:0] key, input logic [3:0] b,
                            input bit kill, input bit resp);
    int div;
    int want;
    div = (k == 0) ? 1 : 3;
    m_step[k] = 0;
    if (resp) begin
      model_reset(k);
      return;
    end
    if (kill) begin
      if (m_mode[k] != MS_FROZ) begin
        m_resume[k] = (m_mode[k] == MS_MOVE);
        m_mode[k] = MS_FROZ;
      end
      return;
    end
    if (m_mode[k] == MS_FROZ) begin
      m_mode[k] = m_resume[k] ? MS_MOVE : MS_STOP;
      return;
    end
    case (key)
      8'h04:   want = 2;
      8'h07:   want = 3;
      8'h16:   want = 1;
      8'h1A:   want = 0;
      default: want = -1;
    endcase
    if (want >= 0) begin
      if (!b[3 - want]) begin
        m_dir[k] = want; m_qv[k] = 0; m_mode[k] = MS_MOVE;
      end else begin
        m_qv[k] = 1; m_qdir[k] = want; m_qleft[k] = TBUF;
      end
    end else if (m_qv[k] != 0) begin
      if (!b[3 - m_qdir[k]]) begin
        m_dir[k] = m_qdir[k]; m_qv[k] = 0; m_mode[k] = MS_MOVE;
      end else begin
        m_qleft[k]--;
        if (m_qleft[k] == 0) m_qv[k] = 0;
      end
    end
    m_frames[k]++;
    if ((m_frames[k] % div == 0) && (m_mode[k] == MS_MOVE)) begin
      if (b[3 - m_dir[k]]) begin
        m_mode[k] = MS_STOP;
      end else begin
        m_step[k] = 1;
        case (m_dir[k])
          0:       m_y[k] = (m_y[k] - 1) & ((1 << W) - 1);
          1:       m_y[k] = (m_y[k] + 1) & ((1 << W) - 1);
          2:       m_x[k] = (m_x[k] < T_MIN + 1) ? T_MAX : m_x[k] - 1;
          default: m_x[k] = (m_x[k] + 1 > T_MAX) ? T_MIN : m_x[k] + 1;
        endcase
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int r;

    // Reset asserted mid-move, then released and idle
    repeat (2) @(posedge frame_clk);
    #1 Reset_n = 1'b1;
    t_key = 8'h07;
    repeat (3) step();
    #2 Reset_n = 1'b0;
    #1 check_out(0, "reset_async", XC, YC, 2, 0, 0, 0, 0);
    t_key = 8'h00;
    step();
    Reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_out(0, $sformatf("reset_hold%0d", i), XC, YC, 2, 0, 0, 0, 0);
    end

    // Basic move, wall stop, queued turn taken, queued turn expiring
    add_vec(8'h07, 4'h0, 321, 274, 3, 1, 0, 1, 0);
    add_vec(8'h07, 4'h0, 322, 274, 3, 1, 0, 1, 0);
    add_vec(8'h07, 4'h1, 322, 274, 3, 0, 0, 0, 1);
    add_vec(8'h07, 4'h0, 323, 274, 3, 1, 0, 1, 0);
    add_vec(8'h1A, 4'h8, 324, 274, 3, 1, 0, 1, 1);
    add_vec(8'h00, 4'h8, 325, 274, 3, 1, 0, 1, 1);
    add_vec(8'h00, 4'h8, 326, 274, 3, 1, 0, 1, 1);
    add_vec(8'h00, 4'h0, 326, 273, 0, 1, 0, 1, 0);
    add_vec(8'h07, 4'h0, 327, 273, 3, 1, 0, 1, 0);
    add_vec(8'h1A, 4'h8, 328, 273, 3, 1, 0, 1, 1);
    for (int i = 0; i < 7; i++) add_vec(8'h00, 4'h8, 329 + i, 273, 3, 1, 0, 1, 1);
    add_vec(8'h00, 4'h8, 336, 273, 3, 1, 0, 1, 0);
    foreach (vecs[i]) begin
      t_key = vecs[i].key;
      t_blk = vecs[i].blk;
      step();
      check_out(0, $sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].d,
                vecs[i].mv, vecs[i].fz, vecs[i].st, vecs[i].qv);
    end

    // Tunnel wrap both ways
    t_key = 8'h00; t_blk = 4'h0; t_resp = 1'b1;
    step();
    t_resp = 1'b0;
    check_out(0, "respawn_tunnel", XC, YC, 2, 0, 0, 0, 0);
    t_key = 8'h04;
    repeat (200) step();
    check_out(0, "tunnel_at_min", T_MIN, YC, 2, 1, 0, 1, 0);
    step();
    check_out(0, "tunnel_wrap_left", T_MAX, YC, 2, 1, 0, 1, 0);
    t_key = 8'h07;
    step();
    check_out(0, "tunnel_wrap_right", T_MIN, YC, 3, 1, 0, 1, 0);

    // Speed divider on the SPEED_DIV=3 instance
    t_key = 8'h00; t_resp = 1'b1;
    step();
    t_resp = 1'b0;
    t_key = 8'h07;
    pulses = 0;
    for (int i = 1; i <= 9; i++) begin
      step();
      pulses += int'(if_b.Step_Pulse);
      chk($sformatf("div_pulse_e%0d", i), int'(if_b.Step_Pulse), (i % 3 == 0) ? 1 : 0);
      if (i == 3) chk("div_x_after3", int'(if_b.PosX), 321);
      if (i == 9) chk("div_x_after9", int'(if_b.PosX), 323);
    end
    chk("div_pulse_count", pulses, 3);

    // Kill freeze, thaw, then Kill+Respawn together
    t_key = 8'h00; t_resp = 1'b1;
    step();
    t_resp = 1'b0;
    t_key = 8'h07;
    repeat (3) step();
    check_out(0, "pre_kill", 323, YC, 3, 1, 0, 1, 0);
    t_kill = 1'b1; t_key = 8'h04;
    for (int i = 0; i < 5; i++) begin
      step();
      check_out(0, $sformatf("kill%0d", i), 323, YC, 3, 0, 1, 0, 0);
    end
    t_kill = 1'b0; t_key = 8'h00;
    step();
    check_out(0, "thaw", 323, YC, 3, 1, 0, 0, 0);
    step();
    check_out(0, "thaw_move", 324, YC, 3, 1, 0, 1, 0);
    t_key = 8'h1A; t_blk = 4'h8;
    step();
    check_out(0, "queue_before_respawn", 325, YC, 3, 1, 0, 1, 1);
    t_key = 8'h00; t_blk = 4'h0; t_kill = 1'b1; t_resp = 1'b1;
    step();
    check_out(0, "kill_and_respawn", XC, YC, 2, 0, 0, 0, 0);
    t_kill = 1'b0; t_resp = 1'b0;

    // Randomized run of both instances against the reference model
    Reset_n = 1'b0;
    step();
    Reset_n = 1'b1;
    model_reset(0);
    model_reset(1);
    for (int n = 0; n < 2000; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    t_key = 8'h04;
        2, 3:    t_key = 8'h07;
        4:       t_key = 8'h16;
        5:       t_key = 8'h1A;
        6:       t_key = 8'($urandom);
        default: t_key = 8'h00;
      endcase
      t_blk  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 19) == 0) t_kill = ~t_kill;
      t_resp = ($urandom_range(0, 99) == 0);
      model_edge(0, t_key, t_blk, t_kill, t_resp);
      model_edge(1, t_key, t_blk, t_kill, t_resp);
      step();
      for (int k = 0; k < 2; k++) begin
        check_out(k, $sformatf("rnd%0d_u%0d", n, k), m_x[k], m_y[k], m_dir[k],
                  (m_mode[k] == MS_MOVE) ? 1 : 0, (m_mode[k] == MS_FROZ) ? 1 : 0,
                  m_step[k], m_qv[k]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
